// File: rtl/layout_context_stack.sv
`default_nettype none
// ============================================================================
// Module      : layout_context_stack
// Description : Layout-state engine for the HTML renderer. Holds the current
//               layout frame (text cursor, text colour/size, block box and
//               block colours) and a hardware stack of parent frames, so that
//               nested block elements save their parent context on open and
//               restore it on close. Tracks the glyph-advance cursor and
//               breaks lines against the current block's content edge.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock             in   system clock, all state on posedge
//   resetn            in   synchronous active-low reset
//   push              in   open block element (save frame, start child)
//   pop               in   close block element (restore parent frame)
//   att_valid         in   attribute strobe for the current frame
//   att_type          in   `ATT_* attribute code
//   att_value         in   attribute value
//   glyph_adv         in   one glyph drawn at cur_x/cur_y, advance cursor
//   newline           in   force line break
//   cur_x / cur_y     out  text cursor
//   text_color        out  current text colour
//   text_size         out  current text scale
//   rect_x/y/w/h      out  current block box
//   rect_bg           out  block background colour
//   rect_border_color out  block border colour
//   rect_border_en    out  block border enable
//   depth             out  stack pointer (nesting level)
//   overflow          out  sticky: push attempted with a full stack
//   underflow         out  sticky: pop attempted at root
//   clipped           out  sticky: cursor reached SCREEN_H
//   hclipped          out  sticky: cursor saturated at SCREEN_W-1
//                          (present only without LAYOUT_WORD_WRAP_EN)
// Configuration macro
//   LAYOUT_WORD_WRAP_EN : defined   -> glyph advance wraps at the right edge
//                         undefined -> no wrap, cur_x saturates, hclipped port
// Priority of coincident strobes: pop > push > att_valid > glyph_adv > newline
// ============================================================================

`ifndef ATTRIBUTE_TYPE_BITES
`define ATTRIBUTE_TYPE_BITES 4
`endif
`ifndef ATTRIBUTE_VAL_BITES
`define ATTRIBUTE_VAL_BITES 9
`endif
`ifndef ATT_COLOR
`define ATT_COLOR   4'd1
`define ATT_SIZE    4'd2
`define ATT_WIDTH   4'd3
`define ATT_HEIGHT  4'd4
`define ATT_BG      4'd5
`define ATT_BORDER  4'd6
`define ATT_MARGIN  4'd7
`define ATT_PADDING 4'd8
`endif

module layout_context_stack #(
   parameter int X_W      = 9,
   parameter int Y_W      = 8,
   parameter int COLOR_W  = 3,
   parameter int SIZE_W   = 4,
   parameter int DEPTH    = 4,
   parameter int SCREEN_W = 320,
   parameter int SCREEN_H = 240,
   parameter int FONT_W   = 5,
   parameter int FONT_H   = 7,
   parameter int KERN     = 1
) (
   input  logic                              clock,
   input  logic                              resetn,
   input  logic                              push,
   input  logic                              pop,
   input  logic                              att_valid,
   input  logic [`ATTRIBUTE_TYPE_BITES-1:0]  att_type,
   input  logic [`ATTRIBUTE_VAL_BITES-1:0]   att_value,
   input  logic                              glyph_adv,
   input  logic                              newline,
   output logic [X_W-1:0]                    cur_x,
   output logic [Y_W-1:0]                    cur_y,
   output logic [COLOR_W-1:0]                text_color,
   output logic [SIZE_W-1:0]                 text_size,
   output logic [X_W-1:0]                    rect_x,
   output logic [Y_W-1:0]                    rect_y,
   output logic [X_W-1:0]                    rect_w,
   output logic [Y_W-1:0]                    rect_h,
   output logic [COLOR_W-1:0]                rect_bg,
   output logic [COLOR_W-1:0]                rect_border_color,
   output logic                              rect_border_en,
   output logic [$clog2(DEPTH+1)-1:0]        depth,
   output logic                              overflow,
   output logic                              underflow,
   output logic                              clipped
`ifndef LAYOUT_WORD_WRAP_EN
   ,
   output logic                              hclipped
`endif
);

   // Stack pointer width, stack address width and the width used for all
   // cursor arithmetic (wide enough that no intermediate sum can wrap).
   localparam int c_dw = $clog2(DEPTH + 1);
   localparam int c_aw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_ww = ((X_W > Y_W) ? X_W : Y_W) + SIZE_W + 2;

   localparam logic [c_dw-1:0] c_depth_max = c_dw'(DEPTH);
   localparam logic [c_ww-1:0] c_adv_unit  = c_ww'(FONT_W + KERN);
   localparam logic [c_ww-1:0] c_font_h    = c_ww'(FONT_H);
   localparam logic [c_ww-1:0] c_screen_h  = c_ww'(SCREEN_H);
`ifdef LAYOUT_WORD_WRAP_EN
   localparam logic [c_ww-1:0] c_font_w    = c_ww'(FONT_W);
   localparam logic [c_ww-1:0] c_screen_w  = c_ww'(SCREEN_W);
`else
   localparam logic [c_ww-1:0] c_screen_w_m1 = c_ww'(SCREEN_W - 1);
`endif

   // One layout frame. base_x/base_y record where the block was opened
   // (parent content-left and parent cursor y); MARGIN offsets from them, so
   // re-applying MARGIN or mixing it with PADDING never accumulates.
   typedef struct packed {
      logic [X_W-1:0]     cur_x;
      logic [Y_W-1:0]     cur_y;
      logic [COLOR_W-1:0] color;
      logic [SIZE_W-1:0]  size;
      logic [X_W-1:0]     rect_x;
      logic [Y_W-1:0]     rect_y;
      logic [X_W-1:0]     rect_w;
      logic [Y_W-1:0]     rect_h;
      logic [COLOR_W-1:0] bg;
      logic               border_en;
      logic [COLOR_W-1:0] border_color;
      logic [X_W-1:0]     pad;
      logic [X_W-1:0]     margin;
      logic [X_W-1:0]     base_x;
      logic [Y_W-1:0]     base_y;
   } frame_t;

   frame_t            r_f;
   frame_t            r_stack [0:(2**c_aw)-1];
   logic [c_dw-1:0]   r_depth;
   logic              r_overflow;
   logic              r_underflow;
   logic              r_clipped;
`ifndef LAYOUT_WORD_WRAP_EN
   logic              r_hclipped;
   logic              w_nhclp;
`endif

   frame_t            w_nf;
   frame_t            w_root;
   frame_t            w_parent;
   logic [c_dw-1:0]   w_nd;
   logic              w_novf;
   logic              w_nunf;
   logic              w_nclp;
   logic              w_push_ok;
   logic [c_aw-1:0]   w_pop_idx;

   logic [c_ww-1:0]   w_size;
   logic [c_ww-1:0]   w_left;
   logic [c_ww-1:0]   w_line;
   logic [c_ww-1:0]   w_nx;
   logic [c_ww-1:0]   w_child_bot;
   logic [c_ww-1:0]   w_child_txt;
   logic [c_ww-1:0]   w_y_req;
   logic              w_y_upd;
   logic [SIZE_W-1:0] w_att_size;
`ifdef LAYOUT_WORD_WRAP_EN
   logic [c_ww-1:0]   w_right;
`endif

   // ------------------------------------------------------------------------
   // Root frame: full-screen block, cursor at origin, text scale 1.
   // ------------------------------------------------------------------------
   always_comb begin
      w_root        = '0;
      w_root.size   = SIZE_W'(1);
      w_root.rect_w = X_W'(SCREEN_W);
      w_root.rect_h = Y_W'(SCREEN_H);
   end

   // ------------------------------------------------------------------------
   // Geometry of the current frame.
   // ------------------------------------------------------------------------
   assign w_size      = c_ww'(r_f.size);
   assign w_left      = c_ww'(r_f.rect_x) + c_ww'(r_f.pad);
   assign w_line      = c_font_h * w_size;
   assign w_nx        = c_ww'(r_f.cur_x) + (c_adv_unit * w_size);
   // The lowest point a closing child has consumed: its declared box plus
   // margin, or the bottom of its last text line, whichever is further down.
   assign w_child_bot = c_ww'(r_f.rect_y) + c_ww'(r_f.rect_h) + c_ww'(r_f.margin);
   assign w_child_txt = c_ww'(r_f.cur_y) + w_line;
`ifdef LAYOUT_WORD_WRAP_EN
   // A zero-width block is unconstrained and extends to the screen edge.
   assign w_right     = (r_f.rect_w == '0) ? c_screen_w
                        : (c_ww'(r_f.rect_x) + c_ww'(r_f.rect_w) - c_ww'(r_f.pad));
`endif

   assign w_pop_idx   = c_aw'(r_depth - 1'b1);
   assign w_parent    = r_stack[w_pop_idx];
   assign w_push_ok   = !pop && push && (r_depth < c_depth_max);
   assign w_att_size  = SIZE_W'(att_value);

   // ------------------------------------------------------------------------
   // Next-frame logic. Exactly one strobe is honoured per cycle; any cursor-y
   // change is routed through w_y_req so clipping is handled in one place.
   // ------------------------------------------------------------------------
   always_comb begin
      w_nf    = r_f;
      w_nd    = r_depth;
      w_novf  = r_overflow;
      w_nunf  = r_underflow;
      w_nclp  = r_clipped;
`ifndef LAYOUT_WORD_WRAP_EN
      w_nhclp = r_hclipped;
`endif
      w_y_upd = 1'b0;
      w_y_req = '0;

      if (pop) begin
         if (r_depth != '0) begin
            w_nf       = w_parent;
            w_nf.cur_x = w_parent.rect_x + w_parent.pad;
            w_y_req    = c_ww'(w_parent.cur_y);
            if (w_child_bot > w_y_req) begin
               w_y_req = w_child_bot;
            end
            if (w_child_txt > w_y_req) begin
               w_y_req = w_child_txt;
            end
            w_y_upd = 1'b1;
            w_nd    = r_depth - 1'b1;
         end else begin
            // Closing the root: restore root defaults but keep the cursor.
            w_nunf     = 1'b1;
            w_nf       = w_root;
            w_nf.cur_x = r_f.cur_x;
            w_nf.cur_y = r_f.cur_y;
         end
      end else if (push) begin
         if (w_push_ok) begin
            w_nf.rect_x       = X_W'(w_left);
            w_nf.rect_y       = r_f.cur_y;
            w_nf.rect_w       = '0;
            w_nf.rect_h       = '0;
            w_nf.bg           = '0;
            w_nf.border_en    = 1'b0;
            w_nf.border_color = '0;
            w_nf.pad          = '0;
            w_nf.margin       = '0;
            w_nf.base_x       = X_W'(w_left);
            w_nf.base_y       = r_f.cur_y;
            w_nf.cur_x        = X_W'(w_left);
            w_nf.cur_y        = r_f.cur_y;
            w_nd              = r_depth + 1'b1;
         end else begin
            w_novf = 1'b1;
         end
      end else if (att_valid) begin
         case (att_type)
            `ATT_COLOR:   w_nf.color  = COLOR_W'(att_value);
            `ATT_SIZE:    w_nf.size   = (w_att_size == '0) ? SIZE_W'(1) : w_att_size;
            `ATT_WIDTH:   w_nf.rect_w = X_W'(att_value);
            `ATT_HEIGHT:  w_nf.rect_h = Y_W'(att_value);
            `ATT_BG:      w_nf.bg     = COLOR_W'(att_value);
            `ATT_BORDER: begin
               w_nf.border_en    = 1'b1;
               w_nf.border_color = COLOR_W'(att_value);
            end
            `ATT_MARGIN: begin
               w_nf.margin = X_W'(att_value);
               w_nf.rect_x = r_f.base_x + X_W'(att_value);
               w_nf.rect_y = r_f.base_y + Y_W'(att_value);
               w_nf.cur_x  = w_nf.rect_x + w_nf.pad;
               w_y_req     = c_ww'(w_nf.rect_y) + c_ww'(w_nf.pad);
               w_y_upd     = 1'b1;
            end
            `ATT_PADDING: begin
               w_nf.pad   = X_W'(att_value);
               w_nf.cur_x = r_f.rect_x + X_W'(att_value);
               w_y_req    = c_ww'(r_f.rect_y) + c_ww'(att_value);
               w_y_upd    = 1'b1;
            end
            default: ;
         endcase
      end else if (glyph_adv) begin
`ifdef LAYOUT_WORD_WRAP_EN
         // Wrap when the glyph after this advance would cross the right edge.
         if ((w_nx + (c_font_w * w_size)) > w_right) begin
            w_nf.cur_x = X_W'(w_left);
            w_y_req    = c_ww'(r_f.cur_y) + w_line;
            w_y_upd    = 1'b1;
         end else begin
            w_nf.cur_x = X_W'(w_nx);
         end
`else
         if (w_nx > c_screen_w_m1) begin
            w_nf.cur_x = X_W'(c_screen_w_m1);
            w_nhclp    = 1'b1;
         end else begin
            w_nf.cur_x = X_W'(w_nx);
         end
`endif
      end else if (newline) begin
         w_nf.cur_x = X_W'(w_left);
         w_y_req    = c_ww'(r_f.cur_y) + w_line;
         w_y_upd    = 1'b1;
      end

      if (w_y_upd) begin
         if (w_y_req >= c_screen_h) begin
            w_nclp     = 1'b1;
            w_nf.cur_y = Y_W'(SCREEN_H - 1);
         end else begin
            w_nf.cur_y = Y_W'(w_y_req);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Current-frame and status registers.
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_f         <= w_root;
         r_depth     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         r_clipped   <= 1'b0;
`ifndef LAYOUT_WORD_WRAP_EN
         r_hclipped  <= 1'b0;
`endif
      end else begin
         r_f         <= w_nf;
         r_depth     <= w_nd;
         r_overflow  <= w_novf;
         r_underflow <= w_nunf;
         r_clipped   <= w_nclp;
`ifndef LAYOUT_WORD_WRAP_EN
         r_hclipped  <= w_nhclp;
`endif
      end
   end

   // Saved parent frames. No reset: entries above depth are never read, and
   // reset returns depth to zero, which discards the whole stack.
   always_ff @(posedge clock) begin
      if (resetn && w_push_ok) begin
         r_stack[r_depth[c_aw-1:0]] <= r_f;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs come straight from the current-frame registers.
   // ------------------------------------------------------------------------
   assign cur_x             = r_f.cur_x;
   assign cur_y             = r_f.cur_y;
   assign text_color        = r_f.color;
   assign text_size         = r_f.size;
   assign rect_x            = r_f.rect_x;
   assign rect_y            = r_f.rect_y;
   assign rect_w            = r_f.rect_w;
   assign rect_h            = r_f.rect_h;
   assign rect_bg           = r_f.bg;
   assign rect_border_color = r_f.border_color;
   assign rect_border_en    = r_f.border_en;
   assign depth             = r_depth;
   assign overflow          = r_overflow;
   assign underflow         = r_underflow;
   assign clipped           = r_clipped;
`ifndef LAYOUT_WORD_WRAP_EN
   assign hclipped          = r_hclipped;
`endif

endmodule

`default_nettype wire

// File: tb/tb_layout_context_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_layout_context_stack
// Description : Self-checking bench for layout_context_stack. Directed steps
//               from the test plan followed by randomized strobes, all
//               compared against a frame-stack reference model built from
//               integer arithmetic and a queue.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef ATTRIBUTE_TYPE_BITES
`define ATTRIBUTE_TYPE_BITES 4
`endif
`ifndef ATTRIBUTE_VAL_BITES
`define ATTRIBUTE_VAL_BITES 9
`endif
`ifndef ATT_COLOR
`define ATT_COLOR   4'd1
`define ATT_SIZE    4'd2
`define ATT_WIDTH   4'd3
`define ATT_HEIGHT  4'd4
`define ATT_BG      4'd5
`define ATT_BORDER  4'd6
`define ATT_MARGIN  4'd7
`define ATT_PADDING 4'd8
`endif

module tb_layout_context_stack;

   localparam int DEPTH = 4;
   localparam int SW    = 320;
   localparam int SH    = 240;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       push = 1'b0, pop = 1'b0, att_valid = 1'b0;
   logic       glyph_adv = 1'b0, newline = 1'b0;
   logic [3:0] att_type = '0;
   logic [8:0] att_value = '0;

   logic [8:0] cur_x, rect_x, rect_w;
   logic [7:0] cur_y, rect_y, rect_h;
   logic [2:0] text_color, rect_bg, rect_border_color;
   logic [3:0] text_size;
   logic       rect_border_en, overflow, underflow, clipped;
   logic [2:0] depth;
`ifndef LAYOUT_WORD_WRAP_EN
   logic       hclipped;
`endif

   layout_context_stack #(.DEPTH(DEPTH)) dut (
      .clock(clock), .resetn(resetn), .push(push), .pop(pop),
      .att_valid(att_valid), .att_type(att_type), .att_value(att_value),
      .glyph_adv(glyph_adv), .newline(newline),
      .cur_x(cur_x), .cur_y(cur_y), .text_color(text_color), .text_size(text_size),
      .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
      .rect_bg(rect_bg), .rect_border_color(rect_border_color),
      .rect_border_en(rect_border_en), .depth(depth),
      .overflow(overflow), .underflow(underflow), .clipped(clipped)
`ifndef LAYOUT_WORD_WRAP_EN
      , .hclipped(hclipped)
`endif
   );

   always #5 clock = ~clock;

   // ---------------- reference model ----------------
   typedef struct {
      int cx, cy, col, sz, rx, ry, rw, rh, bg, ben, bcol, pad, mar, px, py;
   } frame_m;

   frame_m m;
   frame_m stk[$];
   int     ovf, unf, clp, hclp;
   int     total = 0;
   int     bad   = 0;

   function automatic frame_m root_frame();
      frame_m f;
      f = '{default: 0};
      f.sz = 1; f.rw = SW; f.rh = SH;
      return f;
   endfunction

   function automatic int clipy(input int y);
      if (y >= SH) begin
         clp = 1;
         return SH - 1;
      end
      return y;
   endfunction

   task automatic model_step(input bit rn, input bit p, input bit q, input bit a,
                             input int t, input int v, input bit g, input bit n);
      frame_m c;
      int     y, nx, cx0, cy0;
      if (!rn) begin
         m = root_frame(); stk.delete(); ovf = 0; unf = 0; clp = 0; hclp = 0;
      end else if (q) begin
         if (stk.size() > 0) begin
            c = m;
            m = stk.pop_back();
            y = m.cy;
            if (c.ry + c.rh + c.mar > y) y = c.ry + c.rh + c.mar;
            if (c.cy + 7 * c.sz > y)     y = c.cy + 7 * c.sz;
            m.cx = m.rx + m.pad;
            m.cy = clipy(y);
         end else begin
            unf = 1; cx0 = m.cx; cy0 = m.cy;
            m = root_frame(); m.cx = cx0; m.cy = cy0;
         end
      end else if (p) begin
         if (stk.size() < DEPTH) begin
            stk.push_back(m);
            m.rx = m.rx + m.pad; m.ry = m.cy; m.px = m.rx; m.py = m.cy;
            m.rw = 0; m.rh = 0; m.bg = 0; m.ben = 0; m.bcol = 0; m.pad = 0; m.mar = 0;
            m.cx = m.rx; m.cy = m.ry;
         end else begin
            ovf = 1;
         end
      end else if (a) begin
         case (t)
            `ATT_COLOR:   m.col = v;
            `ATT_SIZE:    m.sz = (v == 0) ? 1 : v;
            `ATT_WIDTH:   m.rw = v;
            `ATT_HEIGHT:  m.rh = v;
            `ATT_BG:      m.bg = v;
            `ATT_BORDER:  begin m.ben = 1; m.bcol = v; end
            `ATT_MARGIN:  begin
               m.mar = v; m.rx = m.px + v; m.ry = m.py + v;
               m.cx = m.rx + m.pad; m.cy = clipy(m.ry + m.pad);
            end
            `ATT_PADDING: begin
               m.pad = v; m.cx = m.rx + v; m.cy = clipy(m.ry + v);
            end
            default: ;
         endcase
      end else if (g) begin
         nx = m.cx + 6 * m.sz;
`ifdef LAYOUT_WORD_WRAP_EN
         if (nx + 5 * m.sz > ((m.rw == 0) ? SW : m.rx + m.rw - m.pad)) begin
            m.cx = m.rx + m.pad; m.cy = clipy(m.cy + 7 * m.sz);
         end else m.cx = nx;
`else
         if (nx > SW - 1) begin m.cx = SW - 1; hclp = 1; end
         else m.cx = nx;
`endif
      end else if (n) begin
         m.cx = m.rx + m.pad; m.cy = clipy(m.cy + 7 * m.sz);
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input int exp);
      total++;
      assert (got === 32'(exp)) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("cur_x",   32'(cur_x),             m.cx);
      chk("cur_y",   32'(cur_y),             m.cy);
      chk("color",   32'(text_color),        m.col);
      chk("size",    32'(text_size),         m.sz);
      chk("rect_x",  32'(rect_x),            m.rx);
      chk("rect_y",  32'(rect_y),            m.ry);
      chk("rect_w",  32'(rect_w),            m.rw);
      chk("rect_h",  32'(rect_h),            m.rh);
      chk("bg",      32'(rect_bg),           m.bg);
      chk("bcol",    32'(rect_border_color), m.bcol);
      chk("ben",     32'(rect_border_en),    m.ben);
      chk("depth",   32'(depth),             stk.size());
      chk("ovf",     32'(overflow),          ovf);
      chk("unf",     32'(underflow),         unf);
      chk("clipped", 32'(clipped),           clp);
`ifndef LAYOUT_WORD_WRAP_EN
      chk("hclip",   32'(hclipped),          hclp);
`endif
   endtask

   // Drive one cycle of strobes, let the edge take them, then compare.
   task automatic drive(input bit rn, input bit p, input bit q, input bit a,
                        input int t, input int v, input bit g, input bit n);
      resetn = rn; push = p; pop = q; att_valid = a;
      att_type = 4'(t); att_value = 9'(v); glyph_adv = g; newline = n;
      @(posedge clock);
      #1;
      model_step(rn, p, q, a, t, v, g, n);
      check_all();
      resetn = 1'b1; push = 1'b0; pop = 1'b0; att_valid = 1'b0;
      glyph_adv = 1'b0; newline = 1'b0;
   endtask

   task automatic do_reset();            drive(0, 0, 0, 0, 0, 0, 0, 0); endtask
   task automatic do_push();             drive(1, 1, 0, 0, 0, 0, 0, 0); endtask
   task automatic do_pop();              drive(1, 0, 1, 0, 0, 0, 0, 0); endtask
   task automatic do_att(input int t, input int v); drive(1, 0, 0, 1, t, v, 0, 0); endtask
   task automatic do_glyph();            drive(1, 0, 0, 0, 0, 0, 1, 0); endtask
   task automatic do_nl();               drive(1, 0, 0, 0, 0, 0, 0, 1); endtask

   function automatic int pick_value(input int t);
      case (t)
         `ATT_COLOR, `ATT_BG, `ATT_BORDER: return $urandom_range(0, 7);
         `ATT_SIZE:                        return $urandom_range(0, 15);
         `ATT_WIDTH:   return ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(40, SW);
         `ATT_HEIGHT:                      return $urandom_range(0, SH);
         `ATT_MARGIN, `ATT_PADDING:        return $urandom_range(0, 15);
         default:                          return $urandom_range(0, 511);
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      m = root_frame(); ovf = 0; unf = 0; clp = 0; hclp = 0;

      // Reset state
      do_reset();
      chk("rst_rect_w", 32'(rect_w), 320);
      chk("rst_rect_h", 32'(rect_h), 240);
      chk("rst_size",   32'(text_size), 1);

      // Glyph advance to the right edge
      repeat (52) do_glyph();
      chk("g52_x", 32'(cur_x), 312);
      chk("g52_y", 32'(cur_y), 0);
      do_glyph();
`ifdef LAYOUT_WORD_WRAP_EN
      chk("g53_x", 32'(cur_x), 0);
      chk("g53_y", 32'(cur_y), 7);
`else
      chk("g53_x", 32'(cur_x), 318);
      chk("g53_hclip", 32'(hclipped), 0);
      do_glyph();
      chk("g54_x", 32'(cur_x), 319);
      chk("g54_hclip", 32'(hclipped), 1);
`endif

      // Child block with margin/padding/size
      do_reset();
      do_push();
      do_att(`ATT_MARGIN, 4);
      do_att(`ATT_PADDING, 2);
      do_att(`ATT_WIDTH, 100);
      do_att(`ATT_HEIGHT, 20);
      chk("blk_rx", 32'(rect_x), 4);
      chk("blk_ry", 32'(rect_y), 4);
      chk("blk_rw", 32'(rect_w), 100);
      chk("blk_rh", 32'(rect_h), 20);
      chk("blk_cx", 32'(cur_x), 6);
      chk("blk_cy", 32'(cur_y), 6);
      chk("blk_depth", 32'(depth), 1);
      do_pop();
      chk("blk_pop_depth", 32'(depth), 0);
      chk("blk_pop_cx", 32'(cur_x), 0);
      chk("blk_pop_cy", 32'(cur_y), 28);

      // Colour and size inheritance
      do_push();
      do_att(`ATT_COLOR, 5);
      do_att(`ATT_SIZE, 2);
      do_push();
      chk("inh_color", 32'(text_color), 5);
      chk("inh_size",  32'(text_size), 2);
      do_pop();
      do_pop();
      chk("res_color", 32'(text_color), 0);
      chk("res_size",  32'(text_size), 1);

      // Overflow and underflow
      do_reset();
      repeat (DEPTH + 1) do_push();
      chk("ovf_flag",  32'(overflow), 1);
      chk("ovf_depth", 32'(depth), DEPTH);
      repeat (DEPTH + 1) do_pop();
      chk("unf_flag",  32'(underflow), 1);
      chk("unf_depth", 32'(depth), 0);
      chk("unf_rw",    32'(rect_w), 320);
      chk("unf_rh",    32'(rect_h), 240);

      // Strobe priority
      do_reset();
      do_push();
      drive(1, 1, 1, 0, 0, 0, 0, 0);
      chk("pri_depth", 32'(depth), 0);
      drive(1, 0, 0, 1, `ATT_COLOR, 3, 1, 0);
      chk("pri_color", 32'(text_color), 3);
      chk("pri_cx",    32'(cur_x), 0);

      // Vertical clipping and mid-sequence reset
      do_reset();
      repeat (35) do_nl();
      chk("clip_flag", 32'(clipped), 1);
      chk("clip_y",    32'(cur_y), 239);
      do_push();
      do_att(`ATT_BORDER, 6);
      do_reset();
      chk("mid_rst_clip",  32'(clipped), 0);
      chk("mid_rst_y",     32'(cur_y), 0);
      chk("mid_rst_depth", 32'(depth), 0);
      chk("mid_rst_ben",   32'(rect_border_en), 0);

      // Randomized strobes against the model
      for (int i = 0; i < 3000; i++) begin
         bit rn, p, q, a, g, n;
         int t, v;
         rn = ($urandom_range(0, 199) != 0);
         p  = ($urandom_range(0, 99) < 15);
         q  = ($urandom_range(0, 99) < 12);
         a  = ($urandom_range(0, 99) < 35);
         g  = ($urandom_range(0, 99) < 35);
         n  = ($urandom_range(0, 99) < 10);
         t  = $urandom_range(0, 15);
         v  = pick_value(t);
         drive(rn, p, q, a, t, v, g, n);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
